// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one bit per cycle.
// Define SIGNED_OPS_EN to let op[1] select two's-complement operation.
module mult_div_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;    // partial product high half, or partial remainder
    logic [WIDTH-1:0] lo;    // multiplier shifting out, or dividend shifting into quotient
    logic [WIDTH-1:0] opb;   // multiplicand or divisor magnitude
    logic             is_div, neg_q, neg_r, dbz;

    logic             load, last;
    logic             sgn, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

`ifdef SIGNED_OPS_EN
    assign sgn = op[1];
`else
    logic unused_op_sign;
    assign unused_op_sign = op[1];
    assign sgn = 1'b0;
`endif

    assign sa    = sgn & a[WIDTH-1];
    assign sb    = sgn & b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;
    assign load  = start && (state != RUN);
    assign last  = (state == RUN) && (cnt == CW'(WIDTH-1));
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk) begin
        // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    logic [WIDTH:0]     mul_sum, div_shift;
    logic [WIDTH-1:0]   div_diff, hi_nxt, lo_nxt;
    logic               div_ge;

    always_comb begin
        mul_sum   = {1'b0, hi} + {1'b0, opb & {WIDTH{lo[0]}}};
        div_shift = {hi, lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opb};
        div_diff  = div_shift[WIDTH-1:0] - opb;
        if (is_div) begin
            hi_nxt = div_ge ? div_diff : div_shift[WIDTH-1:0];
            lo_nxt = {lo[WIDTH-2:0], div_ge};
        end else begin
            hi_nxt = mul_sum[WIDTH:1];
            lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Sign fix-up applied to the final iteration's outputs as they enter DONE.
    logic [2*WIDTH-1:0] prod_raw, prod;
    logic [WIDTH-1:0]   quot, rem;

    always_comb begin
        prod_raw = {hi_nxt, lo_nxt};
        prod     = neg_q ? -prod_raw : prod_raw;
        quot     = dbz ? '1 : (neg_q ? -lo_nxt : lo_nxt);
        rem      = neg_r ? -hi_nxt : hi_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: datapath and result registers are cleared too, so an aborted operation leaves all outputs at 0.
            cnt         <= '0;
            hi          <= '0;
            lo          <= '0;
            opb         <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            if (load) begin
                cnt    <= '0;
                hi     <= '0;
                lo     <= op[0] ? mag_a : mag_b;
                opb    <= op[0] ? mag_b : mag_a;
                is_div <= op[0];
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                dbz    <= op[0] && (b == '0);
            end else if (state == RUN) begin
                cnt <= cnt + CW'(1);
                hi  <= hi_nxt;
                lo  <= lo_nxt;
            end
            if (last) begin
                if (is_div) begin
                    result_hi <= rem;
                    result_lo <= quot;
                end else begin
                    {result_hi, result_lo} <= prod;
                end
                div_by_zero <= dbz;
            end
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, multi-cycle corner sequences
// and randomized operations against an arithmetic reference model.
module tb_mult_div_unit;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, div_by_zero;
    logic [W-1:0] result_hi, result_lo;

    int checks   = 0;
    int failures = 0;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result_hi(result_hi), .result_lo(result_lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        logic         dz;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference result from plain integer arithmetic on the captured operands.
    function automatic vec_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        vec_t   r;
        longint sx, sy, p, q, m;
        bit     sg;
`ifdef SIGNED_OPS_EN
        sg = o[1];
`else
        sg = 1'b0;
`endif
        r.op = o; r.a = x; r.b = y;
        sx = sg ? longint'($signed(x)) : longint'(x);
        sy = sg ? longint'($signed(y)) : longint'(y);
        if (!o[0]) begin
            p = sx * sy;
            r.hi = p[2*W-1:W]; r.lo = p[W-1:0]; r.dz = 1'b0;
        end else if (y == '0) begin
            r.hi = x; r.lo = '1; r.dz = 1'b1;
        end else begin
            q = sx / sy;
            m = sx % sy;
            r.hi = m[W-1:0]; r.lo = q[W-1:0]; r.dz = 1'b0;
        end
        return r;
    endfunction

    // One operation from IDLE; operands are scrambled after capture, optional start pulse mid-RUN.
    task automatic run_op(input string name, input vec_t v, input bit mid_start);
        int n, nbusy;
        bit seen;
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        n = 0; nbusy = 0; seen = 1'b0;
        while (n < 40 && !seen) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            start = (mid_start && n == 8);
            op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            if (busy) nbusy++;
            if (done) seen = 1'b1;
        end
        check({name, " done seen"}, 64'(seen), 64'(1));
        check({name, " latency"}, 64'(n), 64'(W + 1));
        check({name, " busy cycles"}, 64'(nbusy), 64'(W));
        check({name, " hi"}, 64'(result_hi), 64'(v.hi));
        check({name, " lo"}, 64'(result_lo), 64'(v.lo));
        check({name, " dz"}, 64'(div_by_zero), 64'(v.dz));
        @(negedge clk);
        check({name, " done single"}, 64'(done), 64'(0));
        check({name, " idle busy"}, 64'(busy), 64'(0));
        check({name, " hold lo"}, 64'(result_lo), 64'(v.lo));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   n, k, last_n, saw;
        vec_t bb[3];

        tbl[0] = '{2'b00, 16'd300,  16'd200,  16'h0000, 16'hEA60, 1'b0};
        tbl[1] = '{2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFE, 16'h0001, 1'b0};
        tbl[2] = '{2'b01, 16'd100,  16'd7,    16'h0002, 16'h000E, 1'b0};
        tbl[3] = '{2'b01, 16'h1234, 16'h0000, 16'h1234, 16'hFFFF, 1'b1};
        tbl[6] = '{2'b11, 16'hFFF0, 16'h0000, 16'hFFF0, 16'hFFFF, 1'b1};
`ifdef SIGNED_OPS_EN
        tbl[4] = '{2'b11, 16'hFFF9, 16'h0002, 16'hFFFF, 16'hFFFD, 1'b0};
        tbl[5] = '{2'b11, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0};
        tbl[7] = '{2'b10, 16'hFFFD, 16'h0005, 16'hFFFF, 16'hFFF1, 1'b0};
`else
        tbl[4] = '{2'b11, 16'hFFF9, 16'h0002, 16'h0001, 16'h7FFC, 1'b0};
        tbl[5] = '{2'b11, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0};
        tbl[7] = '{2'b10, 16'hFFFD, 16'h0005, 16'h0004, 16'hFFF1, 1'b0};
`endif

        // Reset held with start high: reset wins, everything reads 0.
        reset = 1'b1; start = 1'b1; op = 2'b00; a = 16'h1111; b = 16'h2222;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset hi", 64'(result_hi), 64'(0));
        check("reset lo", 64'(result_lo), 64'(0));
        check("reset dz", 64'(div_by_zero), 64'(0));
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        check("post-reset idle", 64'(busy), 64'(0));

        for (int i = 0; i < 8; i++) run_op($sformatf("vec%0d", i), tbl[i], 1'b0);

        // Start pulse during RUN is ignored.
        run_op("mid start", model(2'b01, 16'd50000, 16'd123), 1'b1);

        // Abort on RUN cycle 5 after leaving div_by_zero set.
        run_op("pre-abort", '{2'b01, 16'h00AA, 16'h0000, 16'h00AA, 16'hFFFF, 1'b1}, 1'b0);
        @(negedge clk);
        start = 1'b1; op = 2'b00; a = 16'd1234; b = 16'd567;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("abort in run", 64'(busy), 64'(1));
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(busy), 64'(0));
        check("abort done", 64'(done), 64'(0));
        check("abort hi", 64'(result_hi), 64'(0));
        check("abort lo", 64'(result_lo), 64'(0));
        check("abort dz", 64'(div_by_zero), 64'(0));
        saw = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) saw = 1;
        end
        check("abort no done", 64'(saw), 64'(0));
        run_op("after abort", model(2'b00, 16'd1234, 16'd567), 1'b0);

        // Back-to-back with start held high: done every W+1 cycles.
        bb[0] = model(2'b00, 16'd4321, 16'd99);
        bb[1] = model(2'b01, 16'd60000, 16'd77);
        bb[2] = model(2'b11, 16'hF000, 16'h0030);
        @(negedge clk);
        start = 1'b1; op = bb[0].op; a = bb[0].a; b = bb[0].b;
        n = 0; k = 0; last_n = 0;
        while (k < 3 && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) begin
                check($sformatf("b2b%0d interval", k), 64'(n - last_n), 64'(W + 1));
                check($sformatf("b2b%0d hi", k), 64'(result_hi), 64'(bb[k].hi));
                check($sformatf("b2b%0d lo", k), 64'(result_lo), 64'(bb[k].lo));
                check($sformatf("b2b%0d dz", k), 64'(div_by_zero), 64'(bb[k].dz));
                last_n = n;
                k++;
                if (k < 3) begin
                    op = bb[k].op; a = bb[k].a; b = bb[k].b;
                end else begin
                    start = 1'b0;
                end
            end else begin
                op = 2'($urandom); a = W'($urandom); b = W'($urandom);
            end
        end
        start = 1'b0;
        check("b2b count", 64'(k), 64'(3));

        for (int i = 0; i < 200; i++) begin
            logic [1:0]   ro;
            logic [W-1:0] ra, rb;
            ro = 2'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            if ($urandom_range(0, 9) == 0) rb = '0;
            if ($urandom_range(0, 19) == 0) begin ra = 16'h8000; rb = 16'hFFFF; end
            v = model(ro, ra, rb);
            run_op($sformatf("rand%0d", i), v, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
